// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and the data stage,
// with a fetch starvation guard, a BUSY timeout and per-stage stall outputs.
module mem_port_arbiter #(
  parameter int unsigned AW         = 8,
  parameter int unsigned DW         = 16,
  parameter int unsigned TIMEOUT    = 15,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  input  logic          i_dm_req,
  input  logic          i_dm_we,
  input  logic [AW-1:0] i_dm_addr,
  input  logic [DW-1:0] i_dm_wdata,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic          i_mem_ready,
  input  logic [DW-1:0] i_mem_rdata,
  output logic [DW-1:0] o_if_rdata,
  output logic          o_if_valid,
  output logic [DW-1:0] o_dm_rdata,
  output logic          o_dm_valid,
  output logic          o_stallF,
  output logic          o_stallM,
  output logic          o_err
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e        state_q, state_d;
  logic          owner_dm_q, owner_dm_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          if_valid_q, if_valid_d;
  logic          dm_valid_q, dm_valid_d;
  logic          err_q, err_d;
  logic [7:0]    tmo_q, tmo_d;
  logic [3:0]    starve_q, starve_d;
  logic          starved;
  logic          grant_dm;

  // Data normally wins (older instruction) unless fetch has waited STARVE_MAX grants.
  assign starved  = (starve_q == 4'(STARVE_MAX));
  assign grant_dm = i_dm_req && !(i_if_req && starved);

  always_comb begin
    state_d     = state_q;
    owner_dm_d  = owner_dm_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    err_d       = err_q;
    tmo_d       = tmo_q;
    starve_d    = starve_q;

    unique case (state_q)
      StIdle: begin
        if (i_if_req || i_dm_req) begin
          state_d    = StBusy;
          owner_dm_d = grant_dm;
          if (grant_dm) begin
            mem_we_d    = i_dm_we;
            mem_addr_d  = i_dm_addr;
            mem_wdata_d = i_dm_wdata;
            if (i_if_req && !starved) starve_d = starve_q + 4'd1;
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = i_if_addr;
            starve_d   = 4'd0;
          end
        end
      end
      StBusy: begin
        tmo_d = tmo_q + 8'd1;
        // Ready on the expiry cycle wins over the abort.
        if (i_mem_ready) begin
          state_d = StResp;
          if (owner_dm_q) begin
            dm_valid_d = 1'b1;
            if (!mem_we_q) dm_rdata_d = i_mem_rdata;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = i_mem_rdata;
          end
        end else if (tmo_q + 8'd1 == 8'(TIMEOUT)) begin
          state_d = StResp;
          err_d   = 1'b1;
          if (owner_dm_q) begin
            dm_valid_d = 1'b1;
            dm_rdata_d = '0;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = '0;
          end
        end
      end
      StResp: begin
        tmo_d   = 8'd0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= StIdle;
      owner_dm_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= 8'd0;
      starve_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      owner_dm_q  <= owner_dm_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      starve_q    <= starve_d;
    end
  end

  assign o_mem_req   = (state_q == StBusy);
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_if_valid  = if_valid_q;
  assign o_dm_rdata  = dm_rdata_q;
  assign o_dm_valid  = dm_valid_q;
  assign o_stallF    = i_if_req & ~if_valid_q;
  assign o_stallM    = i_dm_req & ~dm_valid_q;
  assign o_err       = err_q;

endmodule
